sdc_host_arb: RTL
=================

Name: sdc_host_arb

Overview:
- Two-port host arbiter in front of the SDRAM controller host interface (sdr_req / sdr_req_ack / sdr_wr_next / sdr_rd_valid).
- Arbitrates between two independent masters using round-robin.
- Forwards one command at a time, routes write-data strobes and read data to the owning port, and holds ownership until every beat of the burst has completed.
- Sits between the system masters and the SDRAM controller top, in the mclk domain.

Parameters:
- ADDR_W, 22, width of host request address.
- DATA_W, 32, width of host read/write data.
- WDOG_MAX, 255, idle-beat watchdog limit in mclk cycles (used only with the optional feature).

Ports:
- mclk  in  1  master clock.
- s_resetn  in  1  asynchronous active-low reset.
- p0_req, p1_req  in  1  port request; held until that port's ack.
- p0_adr, p1_adr  in  ADDR_W  request address.
- p0_len, p1_len  in  2  burst length code (0=1, 1=2, 2=4, 3=8 beats).
- p0_wr_n, p1_wr_n  in  1  0 = write, 1 = read.
- p0_wr_data, p1_wr_data  in  DATA_W  write data.
- p0_wr_en_n, p1_wr_en_n  in  4  write byte masks (active-low).
- p0_ack, p1_ack  out  1  one-cycle command-accepted pulse.
- p0_wr_next, p1_wr_next  out  1  supply the next write beat.
- p0_rd_valid, p1_rd_valid  out  1  read beat valid.
- p0_rd_data, p1_rd_data  out  DATA_W  read data.
- sdr_req  out  1  request to the controller.
- sdr_req_adr  out  ADDR_W  latched address.
- sdr_req_len  out  2  latched length code.
- sdr_req_wr_n  out  1  latched direction.
- sdr_wr_data  out  DATA_W  owner's write data.
- sdr_wr_en_n  out  4  owner's byte mask.
- sdr_req_ack  in  1  controller accepted the command.
- sdr_wr_next  in  1  controller consumed a write beat.
- sdr_rd_valid  in  1  controller read beat valid.
- sdr_rd_data  in  DATA_W  controller read data.
- sdr_init_done  in  1  SDRAM initialisation complete.
- arb_owner  out  1  current owner port number.
- arb_err  out  1  watchdog abort flag (sticky).

Behaviour:
- Clock and reset: one clock, mclk. Reset s_resetn is asynchronous and active-low.
- Reset values:
  - State is IDLE.
  - sdr_req, all pN_ack, pN_wr_next, pN_rd_valid are 0.
  - sdr_req_adr, sdr_req_len, sdr_req_wr_n are 0.
  - arb_owner is 0. The round-robin pointer (last granted port) is 1, so port 0 wins the first tie.
  - The beat counter is 0. arb_err is 0.
- IDLE:
  - No grant while sdr_init_done is 0.
  - If exactly one pN_req is high, grant that port.
  - If both are high, grant the port that is not the last granted one.
  - On grant: latch the owner's adr/len/wr_n into the sdr_req_* registers, set arb_owner, load the beat counter with 2^len, and assert sdr_req on the next cycle. Go to REQ.
- REQ:
  - sdr_req is held at 1.
  - On sdr_req_ack: deassert sdr_req next cycle, pulse p[owner]_ack for exactly one cycle (the cycle after sdr_req_ack), update the round-robin pointer, and go to XFER.
- XFER:
  - Decrement the beat counter on each sdr_wr_next when the latched wr_n is 0, or on each sdr_rd_valid when wr_n is 1.
  - When a decrement takes the counter to 0, return to IDLE on the next cycle.
  - The next grant can occur in that IDLE cycle, giving a minimum of 1 dead cycle between commands.
- Beat counting in REQ: if a beat arrives in REQ (same cycle as sdr_req_ack or earlier), it is counted.
- Routing (combinational):
  - sdr_wr_data and sdr_wr_en_n follow arb_owner.
  - pN_wr_next = sdr_wr_next & (arb_owner==N) & (state != IDLE).
  - pN_rd_valid = sdr_rd_valid & (arb_owner==N) & (state != IDLE).
  - Both pN_rd_data are driven with sdr_rd_data.
- Stray beats: sdr_wr_next or sdr_rd_valid in IDLE is dropped and not routed.
- Reads never overlap: the next command is not issued until the last read beat is returned.
- Request withdrawal: a pN_req dropped before grant is simply not granted. Withdrawal after grant is ignored; the transfer completes.
- sdr_init_done falling while not IDLE: the current transfer completes, then no new grants are made.
- Reset mid-transfer: immediate return to reset values. No ack or beat is generated afterwards.

Optional Feature:
- Macro: SDC_ARB_WDOG_EN.
- With the macro defined:
  - An 8-bit idle counter clears on grant and on each counted beat, and increments every cycle in REQ/XFER.
  - On reaching WDOG_MAX, go to IDLE, clear the beat counter, and set arb_err (sticky until reset).
  - No pN_ack is generated if the abort happens in REQ.
- Without the macro: no counter is present, arb_err is tied to 0, and the arbiter waits indefinitely.

Test Plan:
- Single write: p0 write, adr 0x000100, len 2, controller acks after 3 cycles, then 4 sdr_wr_next -> p0_ack single pulse; p0_wr_next 4 pulses, p1_wr_next 0; return to IDLE 1 cycle after the 4th beat.
- Fairness: p0 and p1 both request continuously, len 0 reads -> grants alternate 0,1,0,1; first grant is port 0; each port receives exactly its own rd_valid beats with data 0xA5A5_0000+n.
- Init gating: p1_req high while sdr_init_done=0 for 20 cycles -> sdr_req stays 0; sdr_req rises 1 cycle after sdr_init_done=1.
- Read isolation: p0 8-beat read with rd_valid gaps; p1 requests mid-burst -> p1 is not granted until the 8th beat; p1_rd_valid stays 0 throughout.
- Reset mid-transfer: s_resetn pulsed low after 2 of 4 write beats -> all outputs return to reset values asynchronously; no p0_ack or wr_next afterwards; next grant goes to port 0.
- Watchdog (SDC_ARB_WDOG_EN): controller never acks -> after 255 cycles state returns to IDLE, arb_err=1, no p0_ack; without the macro sdr_req stays high and arb_err=0.

Source files
------------

// File: rtl/sdc_host_arb.sv
// Two-port round-robin host arbiter in front of the SDRAM controller host interface (mclk domain).
// Optional idle-beat watchdog enabled by defining SDC_ARB_WDOG_EN.

module sdc_host_arb_port (
  input  logic sel,
  input  logic sdr_wr_next,
  input  logic sdr_rd_valid,
  output logic wr_next,
  output logic rd_valid
);
  assign wr_next  = sel & sdr_wr_next;
  assign rd_valid = sel & sdr_rd_valid;
endmodule

module sdc_host_arb #(
  parameter int ADDR_W   = 22,
  parameter int DATA_W   = 32,
  parameter int WDOG_MAX = 255
) (
  input  logic              mclk,
  input  logic              s_resetn,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p0_adr,
  input  logic [ADDR_W-1:0] p1_adr,
  input  logic [1:0]        p0_len,
  input  logic [1:0]        p1_len,
  input  logic              p0_wr_n,
  input  logic              p1_wr_n,
  input  logic [DATA_W-1:0] p0_wr_data,
  input  logic [DATA_W-1:0] p1_wr_data,
  input  logic [3:0]        p0_wr_en_n,
  input  logic [3:0]        p1_wr_en_n,
  output logic              p0_ack,
  output logic              p1_ack,
  output logic              p0_wr_next,
  output logic              p1_wr_next,
  output logic              p0_rd_valid,
  output logic              p1_rd_valid,
  output logic [DATA_W-1:0] p0_rd_data,
  output logic [DATA_W-1:0] p1_rd_data,
  output logic              sdr_req,
  output logic [ADDR_W-1:0] sdr_req_adr,
  output logic [1:0]        sdr_req_len,
  output logic              sdr_req_wr_n,
  output logic [DATA_W-1:0] sdr_wr_data,
  output logic [3:0]        sdr_wr_en_n,
  input  logic              sdr_req_ack,
  input  logic              sdr_wr_next,
  input  logic              sdr_rd_valid,
  input  logic [DATA_W-1:0] sdr_rd_data,
  input  logic              sdr_init_done,
  output logic              arb_owner,
  output logic              arb_err
);
  localparam int NP = 2;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_XFER = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [1:0]        len;
    logic              wr_n;
  } cmd_t;

  if (WDOG_MAX < 1 || WDOG_MAX > 255) begin : g_wdog_chk
    $error("WDOG_MAX must fit the 8-bit idle counter");
  end

  logic [1:0]    state;
  logic [NP-1:0] req, ack_q, wr_next, rd_valid;
  cmd_t [NP-1:0] cmd;
  logic          rr_last;
  logic [3:0]    beat_cnt, beat_left;
  logic          busy, beat, gnt, gnt_port, wdog_abort;

  assign req    = {p1_req, p0_req};
  assign cmd[0] = {p0_adr, p0_len, p0_wr_n};
  assign cmd[1] = {p1_adr, p1_len, p1_wr_n};

  assign busy      = (state != ST_IDLE);
  // A beat only counts while a command is outstanding and beats remain
  assign beat      = busy && (beat_cnt != 4'd0) && (sdr_req_wr_n ? sdr_rd_valid : sdr_wr_next);
  assign beat_left = beat_cnt - {3'd0, beat};
  assign gnt       = (state == ST_IDLE) && sdr_init_done && (|req);
  assign gnt_port  = (&req) ? ~rr_last : req[1];

`ifdef SDC_ARB_WDOG_EN
  logic [7:0] idle_cnt;
  assign wdog_abort = busy && (idle_cnt == 8'(WDOG_MAX));

  always_ff @(posedge mclk or negedge s_resetn) begin
    if (!s_resetn) begin
      idle_cnt <= 8'd0;
      arb_err  <= 1'b0;
    end else begin
      if (gnt || beat || !busy) idle_cnt <= 8'd0;
      else                      idle_cnt <= idle_cnt + 8'd1;
      if (wdog_abort) arb_err <= 1'b1;
    end
  end
`else
  assign wdog_abort = 1'b0;
  assign arb_err    = 1'b0;
`endif

  always_ff @(posedge mclk or negedge s_resetn) begin
    if (!s_resetn) begin
      state        <= ST_IDLE;
      sdr_req      <= 1'b0;
      sdr_req_adr  <= '0;
      sdr_req_len  <= 2'd0;
      sdr_req_wr_n <= 1'b0;
      arb_owner    <= 1'b0;
      rr_last      <= 1'b1;
      beat_cnt     <= 4'd0;
      ack_q        <= '0;
    end else begin
      ack_q <= '0;
      if (beat) beat_cnt <= beat_left;
      case (state)
        ST_IDLE: if (gnt) begin
          sdr_req_adr  <= cmd[gnt_port].adr;
          sdr_req_len  <= cmd[gnt_port].len;
          sdr_req_wr_n <= cmd[gnt_port].wr_n;
          arb_owner    <= gnt_port;
          beat_cnt     <= 4'd1 << cmd[gnt_port].len;
          sdr_req      <= 1'b1;
          state        <= ST_REQ;
        end
        ST_REQ: if (wdog_abort) begin
          sdr_req  <= 1'b0;
          beat_cnt <= 4'd0;
          state    <= ST_IDLE;
        end else if (sdr_req_ack) begin
          sdr_req          <= 1'b0;
          ack_q[arb_owner] <= 1'b1;
          rr_last          <= arb_owner;
          // all beats may already have arrived before the ack
          state            <= (beat_left == 4'd0) ? ST_IDLE : ST_XFER;
        end
        ST_XFER: if (wdog_abort) begin
          beat_cnt <= 4'd0;
          state    <= ST_IDLE;
        end else if (beat && beat_left == 4'd0) begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NP; i++) begin : g_port
    sdc_host_arb_port u_port (
      .sel          (busy && (arb_owner == 1'(i))),
      .sdr_wr_next  (sdr_wr_next),
      .sdr_rd_valid (sdr_rd_valid),
      .wr_next      (wr_next[i]),
      .rd_valid     (rd_valid[i])
    );
  end

  assign p0_ack      = ack_q[0];
  assign p1_ack      = ack_q[1];
  assign p0_wr_next  = wr_next[0];
  assign p1_wr_next  = wr_next[1];
  assign p0_rd_valid = rd_valid[0];
  assign p1_rd_valid = rd_valid[1];
  assign p0_rd_data  = sdr_rd_data;
  assign p1_rd_data  = sdr_rd_data;
  assign sdr_wr_data = arb_owner ? p1_wr_data : p0_wr_data;
  assign sdr_wr_en_n = arb_owner ? p1_wr_en_n : p0_wr_en_n;
endmodule
